// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (C) and DMA/debug (D) ports.
// Latency: the grant edge is followed by one ACCESS cycle, then a one-cycle ack in RESP. Throughput is one access per 3 cycles.
// Backpressure: req is held until ack; requests wait until IDLE, and round-robin picks between two.
//
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata   core request in; c_ack/c_rdata/c_err completion out
//   d_req/d_we/d_addr/d_wdata   DMA/debug request in; d_ack/d_rdata/d_err completion out
//   mem_read/mem_write/mem_addr/mem_data_wr   memory controls out
//   mem_data_rd, dmem_error                   memory read data and error in

`ifndef D_WORD_WIDTH
`define D_WORD_WIDTH 64
`endif

module dmem_arbiter #(
    parameter int DATA_DEPTH = 1024,
    parameter int W          = `D_WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         c_req,
    input  logic         c_we,
    input  logic [W-1:0] c_addr,
    input  logic [W-1:0] c_wdata,
    output logic         c_ack,
    output logic [W-1:0] c_rdata,
    output logic         c_err,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [W-1:0] d_addr,
    input  logic [W-1:0] d_wdata,
    output logic         d_ack,
    output logic [W-1:0] d_rdata,
    output logic         d_err,
    output logic         mem_read,
    output logic         mem_write,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_data_wr,
    input  logic [W-1:0] mem_data_rd,
    input  logic         dmem_error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Highest start address whose 8-byte window still fits in the memory.
    localparam logic [W-1:0] LAST_OK = W'(DATA_DEPTH - 8);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_prio;       // 0 = C wins a tie, 1 = D wins a tie
    logic         r_gnt;        // port owning the current access: 0 = C, 1 = D
    logic         r_we;
    logic [W-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic [W-1:0] r_rdata;
    logic         r_err;

    logic         w_grant_vld;
    logic         w_grant_id;
    logic         w_range_err;

    always_comb begin
        w_grant_vld = c_req | d_req;
        // A lone request wins outright; prio only breaks a tie.
        w_grant_id  = (c_req & d_req) ? r_prio : d_req;
        w_range_err = (r_addr > LAST_OK) | dmem_error;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every output is forced low while rst_n is low, so a reset landing in
    // ACCESS commits no write and a reset landing in RESP produces no ack.
    always_comb begin
        w_state_nxt = r_state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_data_wr = '0;
        c_ack       = 1'b0;
        c_rdata     = '0;
        c_err       = 1'b0;
        d_ack       = 1'b0;
        d_rdata     = '0;
        d_err       = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        w_state_nxt = ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_addr    = r_addr;
                    mem_data_wr = r_wdata;
                    mem_read    = !w_range_err && !r_we;
                    mem_write   = !w_range_err && r_we;
                    w_state_nxt = ST_RESP;
                end
                ST_RESP: begin
                    if (r_gnt) begin
                        d_ack   = 1'b1;
                        d_rdata = r_rdata;
                        d_err   = r_err;
                    end else begin
                        c_ack   = 1'b1;
                        c_rdata = r_rdata;
                        c_err   = r_err;
                    end
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio  <= 1'b0;
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_gnt   <= w_grant_id;
                        r_we    <= w_grant_id ? d_we    : c_we;
                        r_addr  <= w_grant_id ? d_addr  : c_addr;
                        r_wdata <= w_grant_id ? d_wdata : c_wdata;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= (!w_range_err && !r_we) ? mem_data_rd : '0;
                    r_err   <= w_range_err;
                end
                ST_RESP: begin
                    r_prio <= ~r_gnt;
                end
                default: begin
                    r_prio <= r_prio;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, multi-cycle sequences and randomized traffic for dmem_arbiter.
// Latency: n/a (bench).
// Backpressure: n/a (bench).

module tb_dmem_arbiter;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, c_ack, c_err;
    logic [63:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        mem_read, mem_write, dmem_error;
    logic [63:0] mem_addr, mem_data_wr, mem_data_rd;

    int n_cmp  = 0;
    int n_fail = 0;
    bit saw_wr;

    logic [7:0] mem_bytes [DEPTH];   // stand-in for the attached memory
    logic [7:0] ref_mem   [DEPTH];   // reference model contents

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd), .dmem_error(dmem_error)
    );

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (a[63:10] == 54'd0 && int'(a[9:0]) + k < DEPTH)
                w[8*k +: 8] = mem_bytes[int'(a[9:0]) + k];
        end
        return w;
    endfunction

    assign mem_data_rd = mem_word(mem_addr);

    always @(posedge clk) begin
        if (mem_write) begin
            for (int k = 0; k < 8; k++) begin
                if (mem_addr[63:10] == 54'd0 && int'(mem_addr[9:0]) + k < DEPTH)
                    mem_bytes[int'(mem_addr[9:0]) + k] = mem_data_wr[8*k +: 8];
            end
        end
    end

    function automatic logic [7:0] pat_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    function automatic logic [63:0] pat_word(input int a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = pat_byte(a + k);
        return w;
    endfunction

    function automatic bit in_range(input logic [63:0] a);
        return a <= 64'(DEPTH - 8);
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = ref_mem[int'(a[9:0]) + k];
        return w;
    endfunction

    task automatic ref_write(input logic [63:0] a, input logic [63:0] d);
        for (int k = 0; k < 8; k++) ref_mem[int'(a[9:0]) + k] = d[8*k +: 8];
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drop_all();
        c_req = 1'b0; d_req = 1'b0; dmem_error = 1'b0;
    endtask

    // Waits for the next ack; port: 0 = C, 1 = D, 2 = both at once, -1 = timeout.
    task automatic wait_ack(output int port, output int cyc);
        port = -1;
        cyc  = 0;
        while (port < 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            saw_wr |= mem_write;
            if (c_ack || d_ack) port = (c_ack && d_ack) ? 2 : (c_ack ? 0 : 1);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          derr;
        bit          exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input bit p, input bit we, input logic [63:0] a,
                                input logic [63:0] wd, input bit derr,
                                input bit ee, input logic [63:0] er);
        vec_t v;
        v.port = p; v.we = we; v.addr = a; v.wdata = wd;
        v.derr = derr; v.exp_err = ee; v.exp_rdata = er;
        return v;
    endfunction

    task automatic do_txn(input vec_t v, input string tag);
        int got, cyc;
        drop_all();
        @(negedge clk);
        dmem_error = v.derr;
        if (v.port) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
        end
        saw_wr = 1'b0;
        wait_ack(got, cyc);
        chk({tag, "_port"}, 64'(got), 64'(v.port));
        chk({tag, "_lat"}, 64'(cyc), 64'd2);
        chk({tag, "_err"}, v.port ? 64'(d_err) : 64'(c_err), 64'(v.exp_err));
        chk({tag, "_rdata"}, v.port ? d_rdata : c_rdata, v.exp_rdata);
        chk({tag, "_wr"}, 64'(saw_wr), 64'(v.we && !v.exp_err));
        chk({tag, "_other"}, v.port ? (c_rdata | 64'({c_ack, c_err})) : (d_rdata | 64'({d_ack, d_err})), 64'd0);
        if (v.we && !v.exp_err) ref_write(v.addr, v.wdata);
        drop_all();
    endtask

    vec_t vecs[13];

    bit          ract  [2];
    bit          rwe   [2];
    logic [63:0] raddr [2];
    logic [63:0] rwd   [2];
    int          rothr [2];
    int          rage  [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        int p, cy;
        int order[4];
        logic [63:0] crd[4];
        int cyc_of[4];
        int nc;
        logic [63:0] e_rd;
        bit e_err;

        for (int i = 0; i < DEPTH; i++) begin
            mem_bytes[i] = pat_byte(i);
            ref_mem[i]   = pat_byte(i);
        end

        vecs[0]  = mk(0, 1, 64'h10, 64'h1122334455667788, 0, 0, 64'h0);
        vecs[1]  = mk(0, 0, 64'h10, 64'h0, 0, 0, 64'h1122334455667788);
        vecs[2]  = mk(1, 1, 64'(DEPTH - 7), 64'hDEADBEEFDEADBEEF, 0, 1, 64'h0);
        vecs[3]  = mk(1, 0, 64'(DEPTH - 8), 64'h0, 0, 0, pat_word(DEPTH - 8));
        vecs[4]  = mk(1, 1, 64'(DEPTH - 8), 64'h0123456789ABCDEF, 0, 0, 64'h0);
        vecs[5]  = mk(0, 0, 64'(DEPTH - 8), 64'h0, 0, 0, 64'h0123456789ABCDEF);
        vecs[6]  = mk(0, 1, 64'h13, 64'hCAFEF00D12345678, 0, 0, 64'h0);
        vecs[7]  = mk(1, 0, 64'h13, 64'h0, 0, 0, 64'hCAFEF00D12345678);
        vecs[8]  = mk(0, 0, 64'h10, 64'h0, 0, 0, 64'h0D12345678667788);
        vecs[9]  = mk(0, 1, 64'h30, 64'h5A5A5A5A5A5A5A5A, 1, 1, 64'h0);
        vecs[10] = mk(0, 0, 64'h30, 64'h0, 0, 0, pat_word(32'h30));
        vecs[11] = mk(1, 0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 0, 1, 64'h0);
        vecs[12] = mk(0, 0, 64'h10, 64'h0, 1, 1, 64'h0);

        // Reset held with both requests high: everything quiet, then C first.
        rst_n = 1'b0; dmem_error = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h10; c_wdata = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h18; d_wdata = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ctl", 64'({c_ack, d_ack, c_err, d_err, mem_read, mem_write}), 64'd0);
            chk("rst_rdata", c_rdata | d_rdata, 64'd0);
            chk("rst_membus", mem_addr | mem_data_wr, 64'd0);
        end
        rst_n = 1'b1;
        wait_ack(p, cy);
        chk("rst_first_port", 64'(p), 64'd0);
        chk("rst_first_lat", 64'(cy), 64'd2);
        chk("rst_first_rdata", c_rdata, pat_word(32'h10));
        c_req = 1'b0;
        wait_ack(p, cy);
        chk("rst_second_port", 64'(p), 64'd1);
        chk("rst_second_lat", 64'(cy), 64'd3);
        chk("rst_second_rdata", d_rdata, pat_word(32'h18));
        drop_all();

        for (int i = 0; i < 13; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted during the ACCESS cycle of a write to 0x40.
        drop_all();
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b1; c_addr = 64'h40; c_wdata = 64'h5555555555555555;
        @(negedge clk);
        chk("midrst_access_wr", 64'(mem_write), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_quiet", 64'({c_ack, d_ack, mem_write}), 64'd0);
        c_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_ack", 64'({c_ack, d_ack}), 64'd0);
        end
        do_txn(mk(1, 0, 64'h40, 64'h0, 0, 0, pat_word(32'h40)), "midrst_read");

        // Contention: C reads 0x20, D writes 0x20; prio now favours C.
        drop_all();
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'hAAAAAAAAAAAAAAAA;
        for (int i = 0; i < 4; i++) begin
            wait_ack(p, cy);
            order[i] = p; cyc_of[i] = cy;
            crd[i] = (p == 1) ? 64'(d_err) : c_rdata;
        end
        drop_all();
        chk("cont_order", {16'(order[0]), 16'(order[1]), 16'(order[2]), 16'(order[3])},
            {16'd0, 16'd1, 16'd0, 16'd1});
        chk("cont_lat0", 64'(cyc_of[0]), 64'd2);
        chk("cont_gap", {16'(cyc_of[1]), 16'(cyc_of[2]), 16'(cyc_of[3])}, {16'd3, 16'd3, 16'd3});
        chk("cont_rd_old", crd[0], pat_word(32'h20));
        chk("cont_d_err", crd[1], 64'd0);
        chk("cont_rd_new", crd[2], 64'hAAAAAAAAAAAAAAAA);
        ref_write(64'h20, 64'hAAAAAAAAAAAAAAAA);

        // Back-to-back single port: one ack every 3 cycles, D silent.
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h0;
        nc = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(p, cy);
            chk($sformatf("b2b%0d_port", i), 64'(p), 64'd0);
            chk($sformatf("b2b%0d_gap", i), 64'(cy), (i == 0) ? 64'd2 : 64'd3);
            chk($sformatf("b2b%0d_rdata", i), c_rdata, ref_read(64'(8 * i)));
            nc++;
            c_addr = 64'(8 * (i + 1));
        end
        drop_all();

        // Randomized traffic against the transaction-level reference.
        for (int q = 0; q < 2; q++) begin
            ract[q] = 0; rothr[q] = 0; rage[q] = 0; rwe[q] = 0; raddr[q] = '0; rwd[q] = '0;
        end
        @(negedge clk);
        for (int cycn = 0; cycn < 600; cycn++) begin
            @(negedge clk);
            if (c_ack && d_ack) chk("rnd_both_ack", 64'd1, 64'd0);
            for (int q = 0; q < 2; q++) begin
                if (ract[q]) rage[q]++;
                if ((q == 0) ? c_ack : d_ack) begin
                    if (!ract[q]) begin
                        chk($sformatf("rnd_spurious_ack%0d", q), 64'd1, 64'd0);
                    end else begin
                        e_err = !in_range(raddr[q]);
                        e_rd  = (e_err || rwe[q]) ? 64'd0 : ref_read(raddr[q]);
                        chk($sformatf("rnd_err%0d", q), (q == 0) ? 64'(c_err) : 64'(d_err), 64'(e_err));
                        chk($sformatf("rnd_rdata%0d", q), (q == 0) ? c_rdata : d_rdata, e_rd);
                        chk($sformatf("rnd_fair%0d", q), 64'(rothr[q] <= 1), 64'd1);
                        if (rwe[q] && !e_err) ref_write(raddr[q], rwd[q]);
                        if (ract[1 - q]) rothr[1 - q]++;
                        ract[q] = 0;
                    end
                end else if (ract[q] && rage[q] > 10) begin
                    chk($sformatf("rnd_timeout%0d", q), 64'(rage[q]), 64'd10);
                    ract[q] = 0;
                end
            end
            for (int q = 0; q < 2; q++) begin
                if (!ract[q] && $urandom_range(1, 0) == 1) begin
                    ract[q] = 1; rothr[q] = 0; rage[q] = 0;
                    rwe[q] = 1'($urandom_range(1, 0));
                    rwd[q] = {$urandom, $urandom};
                    case ($urandom_range(9, 0))
                        0:       raddr[q] = {$urandom, $urandom};
                        1:       raddr[q] = 64'($urandom_range(DEPTH + 8, DEPTH - 7));
                        default: raddr[q] = 64'($urandom_range(DEPTH - 8, 0));
                    endcase
                end
            end
            c_req = ract[0]; c_we = rwe[0]; c_addr = raddr[0]; c_wdata = rwd[0];
            d_req = ract[1]; d_we = rwe[1]; d_addr = raddr[1]; d_wdata = rwd[1];
        end
        drop_all();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
